mem_port_arbiter: RTL

Arbiter and sequencer that shares one single-ported unified memory between the pipeline's instruction-fetch port (PC → IF/ID) and data-memory port (EX/MEM stage). It sits between the two pipeline memory ports and the memory macro. It runs a grant/acknowledge state machine toward a variable-latency memory. It drives per-port stall signals that the hazard detection unit uses to freeze PC, IF/ID and EX/MEM.

---
 rtl/mem_port_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported unified memory between the instruction-fetch port
// and the data-memory port of the pipeline. In IDLE the arbiter grants one
// requester at each rising edge. Data has priority because its access belongs
// to the older instruction. The granted command is registered onto mem_* and
// held stable until mem_ack. mem_ack returns the FSM to IDLE, captures
// mem_rdata for the owning port, and pulses that port's valid flag for one
// cycle.
//
// Optional feature (macro ARB_STARVE_GUARD_EN):
//   Counts consecutive data grants made while fetch is waiting. Once the count
//   reaches STARVE_MAX with both requests pending, the next IDLE arbitration
//   goes to fetch. With the macro undefined, data priority is strict.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   if_req/if_addr     fetch request level and fetch address (PC)
//   if_rdata/if_valid  fetched instruction and its one-cycle completion pulse
//   if_stall           fetch port waiting (combinational)
//   dm_req/dm_we       data request level; 1 = store, 0 = load
//   dm_addr/dm_wdata   data address and store data
//   dm_wsel            store width code, passed through unchanged
//   dm_rdata/dm_valid  load data and its one-cycle completion pulse
//   dm_stall           data port waiting (combinational)
//   mem_req            memory transaction active
//   mem_we/mem_addr/mem_wdata/mem_wsel  registered memory command
//   mem_ack/mem_rdata  one-cycle completion and read data from memory
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_valid,
  output logic                  if_stall,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  input  logic [1:0]            dm_wsel,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_valid,
  output logic                  dm_stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [1:0]            mem_wsel,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_DM = 2'd2
  } state_e;

  state_e                state_q;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [1:0]            mem_wsel_q;
  logic [DATA_WIDTH-1:0] if_rdata_q;
  logic [DATA_WIDTH-1:0] dm_rdata_q;
  logic                  if_valid_q;
  logic                  dm_valid_q;

  logic grant_dm_d;
  logic grant_if_d;
  logic starve_hit;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt_q;
  logic [3:0] starve_cnt_d;

  assign starve_hit = (starve_cnt_q >= 4'(STARVE_MAX));

  // Only data grants that overtake a waiting fetch count toward starvation.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant_if_d) begin
      starve_cnt_d = '0;
    end else if (grant_dm_d) begin
      if (if_req) begin
        starve_cnt_d = (starve_cnt_q == 4'hF) ? starve_cnt_q : starve_cnt_q + 4'd1;
      end else begin
        starve_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  logic unused_starve_max;
  assign unused_starve_max = ^STARVE_MAX;
  assign starve_hit        = 1'b0;
`endif

  // Arbitration is evaluated only in IDLE. In-flight transactions ignore requests.
  always_comb begin
    grant_dm_d = 1'b0;
    grant_if_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (dm_req && !(starve_hit && if_req)) begin
        grant_dm_d = 1'b1;
      end else if (if_req) begin
        grant_if_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wsel_q  <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
    end else begin
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_dm_d) begin
            state_q     <= ST_BUSY_DM;
            mem_req_q   <= 1'b1;
            mem_we_q    <= dm_we;
            mem_addr_q  <= dm_addr;
            mem_wdata_q <= dm_wdata;
            mem_wsel_q  <= dm_wsel;
          end else if (grant_if_d) begin
            state_q    <= ST_BUSY_IF;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= if_addr;
            mem_wsel_q <= 2'd0;
          end
        end
        ST_BUSY_IF: begin
          if (mem_ack) begin
            state_q    <= ST_IDLE;
            mem_req_q  <= 1'b0;
            if_rdata_q <= mem_rdata;
            if_valid_q <= 1'b1;
          end
        end
        ST_BUSY_DM: begin
          // Stores complete the same way. dm_rdata takes whatever the memory returned.
          if (mem_ack) begin
            state_q    <= ST_IDLE;
            mem_req_q  <= 1'b0;
            dm_rdata_q <= mem_rdata;
            dm_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wsel  = mem_wsel_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_valid  = if_valid_q;
  assign dm_valid  = dm_valid_q;

  // The valid cycle releases the stall, so the hazard unit can advance that cycle.
  assign if_stall = if_req & ~if_valid_q;
  assign dm_stall = dm_req & ~dm_valid_q;

endmodule
